// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: miss-handling controller for a 4-line direct-mapped
// instruction cache (128-byte lines, tag = pc[31:9], index = pc[8:7]).
// Owns tag/valid state, accepts one outstanding miss, issues a 32-beat burst
// read, streams returned words into the data array, then installs the line.
//
// Optional feature macro: ICACHE_CRITICAL_WORD_FIRST_EN
//   defined   : burst starts at the missing word, fill_word wraps 31->0
//   undefined : burst starts at word 0 of the line
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   miss_req, miss_pc     fetch miss request (sampled in IDLE only)
//   inv_all               invalidate all lines
//   mem_req/mem_addr      burst read request, held until mem_gnt
//   mem_gnt               request accepted
//   mem_rvalid/mem_rdata  returned beats (gaps allowed)
//   fill_we/idx/word/data data-array write port
//   cache_tag, cache_v    per-line tag and valid
//   cache_load            one-cycle pulse: line installed or already present
//   busy                  refill in progress
module icache_refill_ctrl (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             miss_req,
    input  logic [31:0]      miss_pc,
    input  logic             inv_all,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic             fill_we,
    output logic [1:0]       fill_idx,
    output logic [4:0]       fill_word,
    output logic [31:0]      fill_data,
    output logic [3:0][22:0] cache_tag,
    output logic [3:0]       cache_v,
    output logic             cache_load,
    output logic             busy
);

    localparam int unsigned LINES  = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned WORD_W = 5;
    localparam int unsigned TAG_W  = 23;
    localparam int unsigned XLEN   = 32;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_DONE} state_t;

    state_t                       r_state, w_state_nxt;
    logic [IDX_W-1:0]             r_idx, w_idx_nxt;
    logic [TAG_W-1:0]             r_tag, w_tag_nxt;
    logic [WORD_W-1:0]            r_start, w_start_nxt;
    logic [WORD_W-1:0]            r_beat, w_beat_nxt;
    logic                         r_stale, w_stale_nxt;
    logic                         r_mem_req, w_mem_req_nxt;
    logic [XLEN-1:0]              r_mem_addr, w_mem_addr_nxt;
    logic                         r_fill_we, w_fill_we_nxt;
    logic [WORD_W-1:0]            r_fill_word, w_fill_word_nxt;
    logic [XLEN-1:0]              r_fill_data, w_fill_data_nxt;
    logic [LINES-1:0][TAG_W-1:0]  r_tags, w_tags_nxt;
    logic [LINES-1:0]             r_v, w_v_nxt;
    logic                         r_load, w_load_nxt;
    logic                         r_busy;

    logic [IDX_W-1:0]             w_miss_idx;
    logic [TAG_W-1:0]             w_miss_tag;
    logic [WORD_W-1:0]            w_miss_start;
    logic [XLEN-1:0]              w_miss_addr;
    logic                         w_hit;
    logic                         w_unused_pc_bits;

    assign w_miss_idx       = miss_pc[8:7];
    assign w_miss_tag       = miss_pc[31:9];
    assign w_unused_pc_bits = ^miss_pc[6:0];

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    assign w_miss_start = miss_pc[6:2];
    assign w_miss_addr  = {miss_pc[31:2], 2'b00};
`else
    assign w_miss_start = '0;
    assign w_miss_addr  = {miss_pc[31:7], 7'b0};
`endif

    // A simultaneous invalidate makes the line count as absent.
    assign w_hit = r_v[w_miss_idx] && (r_tags[w_miss_idx] == w_miss_tag) && !inv_all;

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_tag_nxt       = r_tag;
        w_start_nxt     = r_start;
        w_beat_nxt      = r_beat;
        w_stale_nxt     = r_stale | (inv_all && (r_state != S_IDLE));
        w_mem_req_nxt   = r_mem_req;
        w_mem_addr_nxt  = r_mem_addr;
        w_fill_we_nxt   = 1'b0;
        w_fill_word_nxt = r_fill_word;
        w_fill_data_nxt = r_fill_data;
        w_tags_nxt      = r_tags;
        w_v_nxt         = inv_all ? '0 : r_v;
        w_load_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (miss_req) begin
                    if (w_hit) begin
                        w_load_nxt = 1'b1;
                    end else begin
                        w_idx_nxt             = w_miss_idx;
                        w_tag_nxt             = w_miss_tag;
                        w_start_nxt           = w_miss_start;
                        w_beat_nxt            = '0;
                        w_stale_nxt           = 1'b0;
                        w_v_nxt[w_miss_idx]   = 1'b0;
                        w_mem_req_nxt         = 1'b1;
                        w_mem_addr_nxt        = w_miss_addr;
                        w_state_nxt           = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    w_mem_req_nxt = 1'b0;
                    w_state_nxt   = S_FILL;
                end
            end
            S_FILL: begin
                if (mem_rvalid) begin
                    w_fill_we_nxt   = 1'b1;
                    w_fill_word_nxt = WORD_W'(r_start + r_beat);
                    w_fill_data_nxt = mem_rdata;
                    w_beat_nxt      = WORD_W'(r_beat + 5'd1);
                    if (r_beat == 5'd31) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Stale or concurrently invalidated fills install the tag but stay invalid.
                w_tags_nxt[r_idx] = r_tag;
                if (!r_stale && !inv_all) begin
                    w_v_nxt[r_idx] = 1'b1;
                end
                w_load_nxt  = 1'b1;
                w_stale_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_tag       <= '0;
            r_start     <= '0;
            r_beat      <= '0;
            r_stale     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_fill_we   <= 1'b0;
            r_fill_word <= '0;
            r_fill_data <= '0;
            r_tags      <= '0;
            r_v         <= '0;
            r_load      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_tag       <= w_tag_nxt;
            r_start     <= w_start_nxt;
            r_beat      <= w_beat_nxt;
            r_stale     <= w_stale_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_fill_we   <= w_fill_we_nxt;
            r_fill_word <= w_fill_word_nxt;
            r_fill_data <= w_fill_data_nxt;
            r_tags      <= w_tags_nxt;
            r_v         <= w_v_nxt;
            r_load      <= w_load_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign fill_we    = r_fill_we;
    assign fill_idx   = r_idx;
    assign fill_word  = r_fill_word;
    assign fill_data  = r_fill_data;
    assign cache_tag  = r_tags;
    assign cache_v    = r_v;
    assign cache_load = r_load;
    assign busy       = r_busy;

endmodule
